mem_port_ctrl: RTL

Downstream consumer of the two-requester round-robin arbiter's registered grant_1/grant_2.
Owns the single shared memory port. On a grant it latches the winning requester's address/data/command, runs one memory transaction, returns the read data to that requester and releases its stall.
Generates the per-pipeline stall signals that feed the global-stall network.

---
 rtl/mem_port_pkg.sv | 21 ++
 rtl/mem_port_watchdog.sv | 35 +++
 rtl/mem_port_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port controller: state encoding,
// owner encoding and default widths.
package mem_port_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Which requester currently owns the memory port.
    localparam logic OWNER_1 = 1'b0;
    localparam logic OWNER_2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_HOLDOFF
    } state_t;

endpackage

// File: rtl/mem_port_watchdog.sv
// Transaction watchdog for the memory port controller.
// Elaborated only in builds that define MEM_PORT_TIMEOUT_EN.
// The count clears when a transaction is granted and advances while the
// controller is issuing or waiting; it saturates at LIMIT-1 so the expiry
// stays asserted until the controller leaves ISSUE/WAIT.
`ifdef MEM_PORT_TIMEOUT_EN
module mem_port_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] count_reg;

    assign expired = active && (count_reg == CNT_W'(LIMIT - 1));

    // Cycle counter over the ISSUE/WAIT interval of one transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (active && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/mem_port_ctrl.sv
// Shared memory port controller behind a two-requester arbiter.
// Latches the granted requester's command in IDLE, runs one memory
// transaction, returns read data and pulses done to the owner, then spends
// one HOLDOFF cycle so the arbiter's stale grant is not taken as a new one.
// Optional watchdog: define MEM_PORT_TIMEOUT_EN to abort transactions that
// exceed TIMEOUT_CYCLES with err raised alongside done.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              grant_1,
    input  logic              grant_2,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    input  logic              we_1,
    input  logic              we_2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              done_1,
    output logic              done_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    output logic              stall_1,
    output logic              stall_2,
    output logic              err
);

    state_t            state_reg;
    logic              owner_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              done_1_reg;
    logic              done_2_reg;
    logic [DATA_W-1:0] rdata_1_reg;
    logic [DATA_W-1:0] rdata_2_reg;
    logic              err_reg;
    logic              timeout_hit;

    logic [1:0] req_vec;
    logic [1:0] done_vec;
    logic [1:0] stall_vec;

`ifdef MEM_PORT_TIMEOUT_EN
    mem_port_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   ((state_reg == ST_IDLE) && (grant_1 || grant_2)),
        .active  ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)),
        .expired (timeout_hit)
    );
`else
    // Without the watchdog the port waits as long as memory takes; the
    // parameter is referenced only to keep the interface identical.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Stall each requester until its completion pulse.
    assign req_vec  = {req_2, req_1};
    assign done_vec = {done_2_reg, done_1_reg};
    for (genvar gi = 0; gi < 2; gi++) begin : g_stall
        assign stall_vec[gi] = req_vec[gi] & ~done_vec[gi];
    end

    assign stall_1   = stall_vec[0];
    assign stall_2   = stall_vec[1];
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign done_1    = done_1_reg;
    assign done_2    = done_2_reg;
    assign rdata_1   = rdata_1_reg;
    assign rdata_2   = rdata_2_reg;
    assign err       = err_reg;

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            done_1_reg    <= 1'b0;
            done_2_reg    <= 1'b0;
            rdata_1_reg   <= '0;
            rdata_2_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            done_1_reg <= 1'b0;
            done_2_reg <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Requester 1 wins if both grants are ever seen together.
                    if (grant_1) begin
                        owner_reg     <= OWNER_1;
                        mem_addr_reg  <= addr_1;
                        mem_wdata_reg <= wdata_1;
                        mem_we_reg    <= we_1;
                        mem_req_reg   <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end else if (grant_2) begin
                        owner_reg     <= OWNER_2;
                        mem_addr_reg  <= addr_2;
                        mem_wdata_reg <= wdata_2;
                        mem_we_reg    <= we_2;
                        mem_req_reg   <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        if (mem_we_reg) begin
                            done_1_reg <= (owner_reg == OWNER_1);
                            done_2_reg <= (owner_reg == OWNER_2);
                            state_reg  <= ST_DONE;
                        end else begin
                            state_reg  <= ST_WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req_reg <= 1'b0;
                        done_1_reg  <= (owner_reg == OWNER_1);
                        done_2_reg  <= (owner_reg == OWNER_2);
                        err_reg     <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_reg == OWNER_1) begin
                            rdata_1_reg <= mem_rdata;
                        end else begin
                            rdata_2_reg <= mem_rdata;
                        end
                        done_1_reg <= (owner_reg == OWNER_1);
                        done_2_reg <= (owner_reg == OWNER_2);
                        state_reg  <= ST_DONE;
                    end else if (timeout_hit) begin
                        done_1_reg <= (owner_reg == OWNER_1);
                        done_2_reg <= (owner_reg == OWNER_2);
                        err_reg    <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
